// File: rtl/mac_share_arbiter.sv
// mac_share_arbiter: round-robin sharing of one adder and one multiplier among NREQ requesters
module mac_share_arbiter #(
  parameter int NREQ = 2,
  parameter int W = 32,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_mode,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_data,
  output logic              idle
);
  localparam int IW = $clog2(NREQ);
  localparam int D = MUL_LAT - 1;
  logic [IW-1:0] rr, gi;
  logic found, issue, add_iss, mul_iss, mul_done;
  logic [NREQ-1:0] pending, pending_n, elig, iss_vec, done_vec;
  logic [D-1:0] mv, mv_n;
  logic [IW-1:0] mi [D];
  logic [W-1:0] mp [D];
  logic [W-1:0] op_a, op_b;
  // the oldest multiply stage lands next cycle, so that slot is taken for adds
  assign mul_done = mv[D-1];
  assign elig = req & ~pending & (req_mode | {NREQ{~mul_done}});
  always_comb begin
    found = 1'b0;
    gi = '0;
    for (int k = 0; k < NREQ; k++)
      if (!found && elig[(int'(rr) + k) % NREQ]) begin
        found = 1'b1;
        gi = IW'((int'(rr) + k) % NREQ);
      end
  end
  assign issue = found & ~rst;
  assign iss_vec = issue ? NREQ'(1) << gi : '0;
  assign gnt = iss_vec;
  assign op_a = req_a[gi*W +: W];
  assign op_b = req_b[gi*W +: W];
  assign add_iss = issue & ~req_mode[gi];
  assign mul_iss = issue & req_mode[gi];
  assign mv_n = (mv << 1) | D'(mul_iss);
  assign done_vec = (add_iss ? iss_vec : '0) | (mul_done ? NREQ'(1) << mi[D-1] : '0);
  assign pending_n = (pending | iss_vec) & ~done_vec;
  always_ff @(posedge clk)
    if (rst) begin
      rr <= '0;
      pending <= '0;
      mv <= '0;
      rsp_valid <= '0;
      rsp_data <= '0;
      idle <= 1'b1;
    end else begin
      rr <= issue ? (gi == IW'(NREQ - 1) ? '0 : gi + 1'b1) : rr;
      pending <= pending_n;
      mv <= mv_n;
      rsp_valid <= done_vec;
      rsp_data <= mul_done ? mp[D-1] : add_iss ? op_a + op_b : rsp_data;
      idle <= ~|pending_n & ~|mv_n;
    end
  // product is formed at issue and carried down the pipe; validity lives in mv
  always_ff @(posedge clk) begin
    mi[0] <= gi;
    mp[0] <= op_a * op_b;
    for (int k = 1; k < D; k++) begin
      mi[k] <= mi[k-1];
      mp[k] <= mp[k-1];
    end
  end
endmodule

// File: tb/tb_mac_share_arbiter.sv
// tb_mac_share_arbiter: scoreboard bench for the shared add/multiply arbiter
module tb_mac_share_arbiter;
  localparam int NREQ = 2, W = 32, ML = 2;
  typedef struct { int cyc; int idx; logic [W-1:0] data; } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [NREQ-1:0] req, req_mode, gnt, rsp_valid;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [W-1:0] rsp_data;
  logic idle;
  logic [NREQ-1:0] took = '0;
  exp_t sb[$];
  exp_t e;
  int gseq[$], gcyc[$];
  int n_chk = 0, n_err = 0, cyc = 0;
  int cnt[NREQ], mcfg[NREQ];
  logic [W-1:0] ma, mb;
  logic [2*W-1:0] prod;

  mac_share_arbiter #(.NREQ(NREQ), .W(W), .MUL_LAT(ML)) dut (
    .clk(clk), .rst(rst), .req(req), .req_mode(req_mode), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .idle(idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    took = req & gnt;
    if (rst) begin
      sb.delete();
      check("rst_gnt", gnt, 0);
    end else begin
      check("gnt_onehot", gnt & (gnt - 1'b1), 0);
      if (rsp_valid != 0) begin
        if (sb.size() == 0) check("rsp_spurious", rsp_valid, 0);
        else begin
          e = sb.pop_front();
          check("rsp_valid", rsp_valid, 1 << e.idx);
          check("rsp_data", rsp_data, e.data);
          check("rsp_cyc", cyc, e.cyc);
        end
      end
      for (int i = 0; i < NREQ; i++)
        if (took[i]) begin
          ma = req_a[i*W +: W];
          mb = req_b[i*W +: W];
          prod = {{W{1'b0}}, ma} * {{W{1'b0}}, mb};
          sb.push_back('{cyc + (req_mode[i] ? ML : 1), i, req_mode[i] ? prod[W-1:0] : ma + mb});
          gseq.push_back(i);
          gcyc.push_back(cyc);
        end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (rst) cnt[i] = 0;
      else if (took[i]) begin
        cnt[i]--;
        req_a[i*W +: W] = ($urandom_range(3) == 0) ? '1 : $urandom;
        req_b[i*W +: W] = $urandom;
        req_mode[i] = mcfg[i] == 2 ? 1'($urandom_range(1)) : 1'(mcfg[i]);
      end
      req[i] = cnt[i] != 0;
    end
  endtask

  task automatic start(int i, int m, logic [W-1:0] a, logic [W-1:0] b, int n);
    mcfg[i] = m;
    req_mode[i] = m == 2 ? 1'($urandom_range(1)) : 1'(m);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    cnt[i] = n;
    req[i] = 1'b1;
  endtask

  task automatic wait_done(int lim);
    int k = 0;
    while (k < lim && (cnt[0] != 0 || cnt[1] != 0 || sb.size() != 0)) begin
      step();
      k++;
    end
    check("timeout", k < lim, 1);
    step();
    check("idle", idle, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    check("rst_valid", rsp_valid, 0);
    check("rst_data", rsp_data, 0);
    check("rst_idle", idle, 1);
    rst = 1'b0;
    step();
    gseq.delete();
    gcyc.delete();
  endtask

  initial begin
    req = '0; req_mode = '0; req_a = '0; req_b = '0;
    for (int i = 0; i < NREQ; i++) begin cnt[i] = 0; mcfg[i] = 0; end
    do_reset();
    start(0, 0, 7, 5, 1);
    wait_done(20);
    check("add_data", rsp_data, 12);
    start(1, 1, 3, 32'hFFFF_FFFF, 1);
    wait_done(20);
    check("mul_data", rsp_data, 32'hFFFF_FFFD);
    do_reset();
    start(1, 1, 6, 7, 1);
    step();
    start(0, 0, 10, 20, 1);
    wait_done(20);
    check("slot_n", gcyc.size(), 2);
    if (gcyc.size() == 2) check("slot_gap", gcyc[1] - gcyc[0], 2);
    do_reset();
    start(0, 0, 1, 2, 4);
    start(1, 0, 3, 4, 4);
    wait_done(40);
    check("rr_n", gseq.size(), 8);
    for (int k = 0; k < gseq.size(); k++) check("rr_order", gseq[k], k % 2);
    do_reset();
    start(0, 1, 5, 6, 2);
    wait_done(20);
    check("one_out_n", gcyc.size(), 2);
    if (gcyc.size() == 2) check("one_out_gap", gcyc[1] - gcyc[0], ML);
    do_reset();
    start(0, 1, 9, 9, 1);
    step();
    check("busy", idle, 0);
    do_reset();
    step();
    check("post_rst_idle", idle, 1);
    start(0, 0, 4, 4, 1);
    start(1, 0, 8, 8, 1);
    wait_done(20);
    check("post_rst_n", gseq.size(), 2);
    if (gseq.size() != 0) check("post_rst_first", gseq[0], 0);
    do_reset();
    start(0, 2, $urandom, $urandom, 25);
    start(1, 2, $urandom, $urandom, 25);
    wait_done(400);
    check("rand_n", gseq.size(), 50);
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
